// File: rtl/alu_issue_wb.sv
// alu_issue_wb: sequential issue / write-back unit in front of the 16-bit ALU.
// It accepts one register-format instruction per three cycles and owns the
// architectural register file (R0 hardwired to zero) and the carry flag.
// The ALU itself is external and purely combinational: this unit drives
// PORT1/PORT2/ALUCON from registers and samples ALUOUT/CARRY one cycle later.
module alu_issue_wb #(
   parameter int unsigned         DATA_W    = 16,
   parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   // instruction side
   input  logic              INSTR_VALID,
   output logic              INSTR_READY,
   input  logic [3:0]        OPCODE,
   input  logic [2:0]        RD,
   input  logic [2:0]        RS,
   input  logic [2:0]        RT,
   input  logic [7:0]        IMM,
   // ALU side
   output logic [DATA_W-1:0] PORT1,
   output logic [DATA_W-1:0] PORT2,
   output logic [2:0]        ALUCON,
   input  logic [DATA_W-1:0] ALUOUT,
   input  logic              CARRY,
   // status
   output logic              DONE,
   output logic              ERR,
   output logic              CFLAG,
   // debug read port
   input  logic [2:0]        DBG_ADDR,
   output logic [DATA_W-1:0] DBG_DATA
);

   // Opcode map. 10..15 are illegal and produce ERR instead of DONE.
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_SLT = 4'd8;
   localparam logic [3:0] OP_LDI = 4'd9;

   // ALU function selects used for the synthesized instructions.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WB
   } state_t;

   // The parts of the instruction still needed after the accept edge.
   typedef struct packed {
      logic [3:0] op;
      logic [2:0] rd;
   } instr_t;

   state_t            state;
   state_t            state_nxt;
   instr_t            cur;
   logic [DATA_W-1:0] rf [8];
   logic [DATA_W-1:0] result;
   logic              carry_cap;

   logic              accept;
   logic              legal;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] imm_ext;

   // R0 is never written, but gating the read keeps it zero even though
   // its storage is reset to RESET_VAL like every other entry.
   assign rs_val   = (RS == 3'd0)       ? '0 : rf[RS];
   assign rt_val   = (RT == 3'd0)       ? '0 : rf[RT];
   assign DBG_DATA = (DBG_ADDR == 3'd0) ? '0 : rf[DBG_ADDR];

   assign imm_ext  = {{(DATA_W-8){IMM[7]}}, IMM};
   assign accept   = INSTR_VALID && (state == S_IDLE);
   assign legal    = (cur.op <= OP_LDI);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // FSM next state and handshake / status outputs
   always_comb begin
      state_nxt   = state;
      INSTR_READY = 1'b0;
      DONE        = 1'b0;
      ERR         = 1'b0;
      case (state)
         S_IDLE: begin
            INSTR_READY = 1'b1;
            if (INSTR_VALID) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_WB;
         end
         S_WB: begin
            DONE      = legal;
            ERR       = !legal;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Latch opcode and destination on the accept edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur <= '0;
      end else if (accept) begin
         cur <= '{op: OPCODE, rd: RD};
      end
   end

   // ALU drive registers: only an accept edge with a legal opcode moves them,
   // so they hold steady through EXEC and WB and across illegal instructions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         PORT1  <= '0;
         PORT2  <= '0;
         ALUCON <= ALU_ADD;
      end else if (accept) begin
         if (OPCODE <= OP_SRA) begin
            // NOT/SLA/SRA still load PORT2; the ALU ignores it
            PORT1  <= rs_val;
            PORT2  <= rt_val;
            ALUCON <= OPCODE[2:0];
         end else if (OPCODE == OP_SLT) begin
            // SLT is a subtract whose signed-less-than CARRY is the answer
            PORT1  <= rs_val;
            PORT2  <= rt_val;
            ALUCON <= ALU_SUB;
         end else if (OPCODE == OP_LDI) begin
            // LDI passes the immediate through the adder with zero
            PORT1  <= imm_ext;
            PORT2  <= '0;
            ALUCON <= ALU_ADD;
         end
      end
   end

   // Capture the ALU result and carry at the end of EXEC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result    <= '0;
         carry_cap <= 1'b0;
      end else if (state == S_EXEC) begin
         result    <= (cur.op == OP_SLT) ? {{(DATA_W-1){1'b0}}, CARRY} : ALUOUT;
         carry_cap <= CARRY;
      end
   end

   // Register file write-back at the end of WB; R0 writes are dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= RESET_VAL;
      end else if (state == S_WB && legal && cur.rd != 3'd0) begin
         rf[cur.rd] <= result;
      end
   end

   // Carry flag: ADD/SUB/SLT take the ALU carry, logic and shift ops clear
   // it, LDI and illegal opcodes leave it alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         CFLAG <= 1'b0;
      end else if (state == S_WB) begin
         if (cur.op == OP_ADD || cur.op == OP_SUB || cur.op == OP_SLT)
            CFLAG <= carry_cap;
         else if (cur.op <= OP_SRA)
            CFLAG <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: a combinational ALU model sits on the ALU side,
// and a register-file / flag reference model written in plain integer
// arithmetic predicts every observable value.
module tb_alu_issue_wb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [3:0]  OPCODE;
   logic [2:0]  RD, RS, RT;
   logic [7:0]  IMM;
   logic [15:0] PORT1, PORT2;
   logic [2:0]  ALUCON;
   logic [15:0] ALUOUT;
   logic        CARRY;
   logic        DONE, ERR, CFLAG;
   logic [2:0]  DBG_ADDR;
   logic [15:0] DBG_DATA;

   int n_cmp = 0;
   int n_bad = 0;

   // reference state
   logic [15:0] m_rf [8];
   logic        m_cf;
   logic [15:0] m_p1, m_p2;
   logic [2:0]  m_ac;

   always #10 clk = ~clk;

   alu_issue_wb #(.DATA_W(16), .RESET_VAL(16'h0000)) dut (
      .clk(clk), .reset_n(reset_n),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .OPCODE(OPCODE), .RD(RD), .RS(RS), .RT(RT), .IMM(IMM),
      .PORT1(PORT1), .PORT2(PORT2), .ALUCON(ALUCON),
      .ALUOUT(ALUOUT), .CARRY(CARRY),
      .DONE(DONE), .ERR(ERR), .CFLAG(CFLAG),
      .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
   );

   // External ALU model: ADD carry is signed overflow, SUB carry is signed a<b
   always_comb begin
      logic [15:0] s;
      s      = PORT1 + PORT2;
      ALUOUT = 16'h0000;
      CARRY  = 1'b0;
      case (ALUCON)
         3'd0: begin ALUOUT = s; CARRY = (PORT1[15] == PORT2[15]) && (s[15] != PORT1[15]); end
         3'd1: begin ALUOUT = PORT1 - PORT2; CARRY = $signed(PORT1) < $signed(PORT2); end
         3'd2: ALUOUT = PORT1 & PORT2;
         3'd3: ALUOUT = PORT1 | PORT2;
         3'd4: ALUOUT = PORT1 ^ PORT2;
         3'd5: ALUOUT = ~PORT1;
         3'd6: ALUOUT = {PORT1[14:0], 1'b0};
         default: ALUOUT = {PORT1[15], PORT1[15:1]};
      endcase
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_cf = 1'b0; m_p1 = 16'h0000; m_p2 = 16'h0000; m_ac = 3'd0;
   endtask

   // Architectural effect of one instruction, from integer arithmetic
   task automatic model_exec(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                             input logic [7:0] imm);
      logic [15:0] a, b, v;
      int sa, sb;
      a = m_rf[rs]; b = m_rf[rt];
      sa = int'($signed(a)); sb = int'($signed(b));
      v = 16'h0000;
      case (op)
         4'd0: begin v = 16'(sa + sb); m_cf = (sa + sb > 32767) || (sa + sb < -32768); end
         4'd1: begin v = 16'(sa - sb); m_cf = (sa < sb); end
         4'd2: begin v = a & b; m_cf = 1'b0; end
         4'd3: begin v = a | b; m_cf = 1'b0; end
         4'd4: begin v = a ^ b; m_cf = 1'b0; end
         4'd5: begin v = 16'(-sa - 1); m_cf = 1'b0; end
         4'd6: begin v = 16'(sa * 2); m_cf = 1'b0; end
         4'd7: begin v = 16'(sa >>> 1); m_cf = 1'b0; end
         4'd8: begin v = (sa < sb) ? 16'd1 : 16'd0; m_cf = (sa < sb); end
         4'd9: begin v = 16'(int'($signed(imm))); end
         default: ;
      endcase
      if (op <= 4'd8) begin
         m_p1 = a; m_p2 = b; m_ac = (op == 4'd8) ? 3'd1 : op[2:0];
      end else if (op == 4'd9) begin
         m_p1 = v; m_p2 = 16'h0000; m_ac = 3'd0;
      end
      if (op <= 4'd9 && rd != 3'd0) m_rf[rd] = v;
   endtask

   // One instruction through the full handshake, checked at every stage
   task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                           input logic [7:0] imm);
      int t;
      logic lg;
      lg = (op <= 4'd9);
      t = 0;
      while (!INSTR_READY && t < 10) begin @(posedge clk); #1; t++; end
      if (!INSTR_READY) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_timeout: INSTR_READY=%b required 1", INSTR_READY);
      end
      INSTR_VALID = 1'b1; OPCODE = op; RD = rd; RS = rs; RT = rt; IMM = imm;
      model_exec(op, rd, rs, rt, imm);
      @(posedge clk); #1;
      INSTR_VALID = 1'b0;
      OPCODE = 4'($urandom); RD = 3'($urandom); RS = 3'($urandom);
      RT = 3'($urandom); IMM = 8'($urandom);
      // EXEC
      n_cmp++;
      if (PORT1 !== m_p1) begin n_bad++; $display("FAIL exec_port1 op=%0d: got %h want %h", op, PORT1, m_p1); end
      n_cmp++;
      if (PORT2 !== m_p2) begin n_bad++; $display("FAIL exec_port2 op=%0d: got %h want %h", op, PORT2, m_p2); end
      n_cmp++;
      if (ALUCON !== m_ac) begin n_bad++; $display("FAIL exec_alucon op=%0d: got %0d want %0d", op, ALUCON, m_ac); end
      n_cmp++;
      if ({INSTR_READY, DONE, ERR} !== 3'b000) begin
         n_bad++; $display("FAIL exec_status op=%0d: rdy/done/err=%b want 000", op, {INSTR_READY, DONE, ERR});
      end
      @(posedge clk); #1;
      // WB
      n_cmp++;
      if ({INSTR_READY, DONE, ERR} !== {1'b0, lg, !lg}) begin
         n_bad++; $display("FAIL wb_status op=%0d: rdy/done/err=%b want %b", op, {INSTR_READY, DONE, ERR}, {1'b0, lg, !lg});
      end
      @(posedge clk); #1;
      // back in IDLE: architectural state
      n_cmp++;
      if ({INSTR_READY, DONE, ERR} !== 3'b100) begin
         n_bad++; $display("FAIL idle_status op=%0d: rdy/done/err=%b want 100", op, {INSTR_READY, DONE, ERR});
      end
      n_cmp++;
      if (CFLAG !== m_cf) begin n_bad++; $display("FAIL cflag op=%0d: got %b want %b", op, CFLAG, m_cf); end
      for (int r = 0; r < 8; r++) begin
         DBG_ADDR = 3'(r); #1;
         n_cmp++;
         if (DBG_DATA !== m_rf[r]) begin
            n_bad++; $display("FAIL rf_r%0d op=%0d: got %h want %h", r, op, DBG_DATA, m_rf[r]);
         end
      end
   endtask

   task automatic test_reset();
      INSTR_VALID = 1'b0; OPCODE = 4'd0; RD = 3'd0; RS = 3'd0; RT = 3'd0;
      IMM = 8'd0; DBG_ADDR = 3'd0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({INSTR_READY, DONE, ERR, CFLAG} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_status: rdy/done/err/cf=%b want 1000", {INSTR_READY, DONE, ERR, CFLAG});
      end
      n_cmp++;
      if ({PORT1, PORT2, ALUCON} !== 35'd0) begin
         n_bad++; $display("FAIL reset_ports: got %h %h %0d want 0 0 0", PORT1, PORT2, ALUCON);
      end
      for (int r = 0; r < 8; r++) begin
         DBG_ADDR = 3'(r); #1;
         n_cmp++;
         if (DBG_DATA !== 16'h0000) begin n_bad++; $display("FAIL reset_rf_r%0d: got %h want 0000", r, DBG_DATA); end
      end
   endtask

   task automatic test_directed();
      do_instr(4'd9, 3'd1, 3'd0, 3'd0, 8'h7F);   // LDI R1,0x7F
      do_instr(4'd9, 3'd2, 3'd0, 3'd0, 8'hF0);   // LDI R2,0xF0 -> FFF0
      do_instr(4'd0, 3'd3, 3'd1, 3'd2, 8'h00);   // ADD R3 -> 006F, carry 0
      do_instr(4'd8, 3'd4, 3'd2, 3'd1, 8'h00);   // SLT R4 -> 1, carry 1
      do_instr(4'd8, 3'd5, 3'd1, 3'd2, 8'h00);   // SLT R5 -> 0, carry 0
      do_instr(4'd4, 3'd0, 3'd1, 3'd2, 8'h00);   // XOR R0 discarded
      do_instr(4'd12, 3'd3, 3'd1, 3'd2, 8'h55);  // illegal -> ERR
      // spot checks against hand-derived constants
      DBG_ADDR = 3'd3; #1;
      n_cmp++;
      if (DBG_DATA !== 16'h006F) begin n_bad++; $display("FAIL dir_add_r3: got %h want 006F", DBG_DATA); end
      DBG_ADDR = 3'd4; #1;
      n_cmp++;
      if (DBG_DATA !== 16'h0001) begin n_bad++; $display("FAIL dir_slt_r4: got %h want 0001", DBG_DATA); end
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(10, 15));
         else                           op = 4'($urandom_range(0, 9));
         do_instr(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] want [4];
      logic [15:0] prev;
      want[0] = 16'h003F; want[1] = 16'h001F; want[2] = 16'h000F; want[3] = 16'h0007;
      do_instr(4'd9, 3'd1, 3'd0, 3'd0, 8'h7F);
      INSTR_VALID = 1'b1; OPCODE = 4'd7; RD = 3'd1; RS = 3'd1; RT = 3'd1; IMM = 8'h00;
      DBG_ADDR = 3'd1;
      for (int k = 0; k < 4; k++) begin
         prev = m_rf[1];
         n_cmp++;
         if (INSTR_READY !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle k=%0d: got %b want 1", k, INSTR_READY); end
         @(posedge clk); #1;
         n_cmp++;
         if ({INSTR_READY, DONE, PORT1} !== {2'b00, prev}) begin
            n_bad++; $display("FAIL b2b_exec k=%0d: rdy/done/p1=%b/%b/%h want 0/0/%h", k, INSTR_READY, DONE, PORT1, prev);
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({INSTR_READY, DONE} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_wb k=%0d: rdy/done=%b want 01", k, {INSTR_READY, DONE});
         end
         @(posedge clk); #1;
         if (k == 3) INSTR_VALID = 1'b0;
         m_rf[1] = want[k]; m_cf = 1'b0; m_p1 = prev; m_p2 = prev; m_ac = 3'd7;
         #1;
         n_cmp++;
         if (DBG_DATA !== want[k]) begin n_bad++; $display("FAIL b2b_r1 k=%0d: got %h want %h", k, DBG_DATA, want[k]); end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({INSTR_READY, DONE, ERR} !== 3'b100) begin
         n_bad++; $display("FAIL b2b_stop: rdy/done/err=%b want 100", {INSTR_READY, DONE, ERR});
      end
   endtask

   task automatic test_reset_abort();
      // leave CFLAG set and registers nonzero so the reset is visible
      do_instr(4'd9, 3'd2, 3'd0, 3'd0, 8'hF0);
      do_instr(4'd8, 3'd4, 3'd2, 3'd1, 8'h00);
      INSTR_VALID = 1'b1; OPCODE = 4'd0; RD = 3'd6; RS = 3'd1; RT = 3'd1;
      @(posedge clk); #1;
      INSTR_VALID = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({INSTR_READY, DONE, ERR, CFLAG} !== 4'b1000) begin
         n_bad++; $display("FAIL abort_status: rdy/done/err/cf=%b want 1000", {INSTR_READY, DONE, ERR, CFLAG});
      end
      n_cmp++;
      if ({PORT1, PORT2, ALUCON} !== 35'd0) begin
         n_bad++; $display("FAIL abort_ports: got %h %h %0d want 0 0 0", PORT1, PORT2, ALUCON);
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({DONE, ERR} !== 2'b00) begin n_bad++; $display("FAIL abort_pulse c=%0d: done/err=%b want 00", c, {DONE, ERR}); end
      end
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({DONE, ERR} !== 2'b00) begin n_bad++; $display("FAIL abort_after c=%0d: done/err=%b want 00", c, {DONE, ERR}); end
      end
      for (int r = 0; r < 8; r++) begin
         DBG_ADDR = 3'(r); #1;
         n_cmp++;
         if (DBG_DATA !== m_rf[r]) begin n_bad++; $display("FAIL abort_rf_r%0d: got %h want %h", r, DBG_DATA, m_rf[r]); end
      end
      // unit is usable again afterwards
      do_instr(4'd9, 3'd6, 3'd0, 3'd0, 8'h81);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
